// File: rtl/icache_if.sv
// icache_if: single-word / burst AXI4 read channel (AR + R) bundle.
//   master drives araddr/arlen/arsize/arburst/arvalid/rready,
//   slave  drives arready/rdata/rresp/rlast/rvalid.
interface icache_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache in front of fetch.
//   aclk, areset : clock, asynchronous active-high reset
//   s            : fetch-side AXI4 read slave (single-word requests)
//   m            : memory-side AXI4 read master (one INCR burst per line refill)
//   flush        : invalidate all lines; present only with ICACHE_FLUSH_EN defined
module icache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic      aclk,
    input  logic      areset,
`ifdef ICACHE_FLUSH_EN
    input  logic      flush,
`endif
    icache_if.slave   s,
    icache_if.master  m
);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] REFILL_AR = 3'd2;
    localparam logic [2:0] REFILL_R  = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;
    localparam logic [2:0] FLUSH     = 3'd5;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [2:0]            state, state_d;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      req_off;
    logic [31:0]           data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [SETS-1:0]       valid;
    logic [OFF_W-1:0]      beat_cnt;
    logic                  refill_err;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;
    logic                  hit_c;
    logic                  beat_c;
    logic                  last_beat_c;
    logic                  fill_err_c;
    logic                  flush_req_c;
    logic                  unused_c;

    assign req_off = req_addr[OFF_W+1:2];
    assign req_idx = req_addr[OFF_W+2 +: IDX_W];
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

    assign hit_c       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign beat_c      = (state == REFILL_R) && m.rvalid;
    assign last_beat_c = beat_c && m.rlast;
    // A line is only usable if all beats were OKAY and the burst ran its full length.
    assign fill_err_c  = refill_err || (m.rresp != OKAY) || (beat_cnt != OFF_W'(LINE_WORDS - 1));

`ifdef ICACHE_FLUSH_EN
    logic             flush_pend;
    logic [IDX_W-1:0] flush_cnt;
    assign flush_req_c = flush || flush_pend;
`else
    assign flush_req_c = 1'b0;
`endif

    assign unused_c = ^{s.arlen, s.arsize, s.arburst, req_addr[1:0], flush_req_c};

    assign s.rvalid  = (state == RESP);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign s.rlast   = 1'b1;
    assign m.araddr  = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
    assign m.arlen   = 8'(LINE_WORDS - 1);
    assign m.arsize  = 3'b010;
    assign m.arburst = 2'b01;

    // State register and control/status registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            valid      <= '0;
            req_addr   <= '0;
            beat_cnt   <= '0;
            refill_err <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (s.arvalid && s.arready) req_addr <= s.araddr;
                end
                LOOKUP: begin
                    if (hit_c) begin
                        rdata_q <= data_mem[{req_idx, req_off}];
                        rresp_q <= OKAY;
                    end else begin
                        // The victim is overwritten word by word, so drop it now.
                        valid[req_idx] <= 1'b0;
                        beat_cnt       <= '0;
                        refill_err     <= 1'b0;
                    end
                end
                REFILL_R: begin
                    if (m.rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == req_off) rdata_q <= m.rdata;
                        if (m.rresp != OKAY) refill_err <= 1'b1;
                        if (m.rlast) begin
                            rresp_q <= fill_err_c ? SLVERR : OKAY;
                            if (!fill_err_c) valid[req_idx] <= 1'b1;
                        end
                    end
                end
`ifdef ICACHE_FLUSH_EN
                FLUSH: valid[flush_cnt] <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

`ifdef ICACHE_FLUSH_EN
    // Flush requests arriving outside IDLE wait here until IDLE is re-entered.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            if (state == IDLE) begin
                flush_pend <= 1'b0;
                flush_cnt  <= '0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
            if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

    // Line storage: data and tags need no reset, the valid bits guard them.
    always_ff @(posedge aclk) begin
        if (beat_c) data_mem[{req_idx, beat_cnt}] <= m.rdata;
        if (last_beat_c) tag_mem[req_idx] <= req_tag;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state;
        s.arready = 1'b0;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;
        case (state)
            IDLE: begin
`ifdef ICACHE_FLUSH_EN
                if (flush_req_c) begin
                    state_d = FLUSH;
                end else begin
                    s.arready = 1'b1;
                    if (s.arvalid) state_d = LOOKUP;
                end
`else
                s.arready = 1'b1;
                if (s.arvalid) state_d = LOOKUP;
`endif
            end
            LOOKUP:    state_d = hit_c ? RESP : REFILL_AR;
            REFILL_AR: begin
                m.arvalid = 1'b1;
                if (m.arready) state_d = REFILL_R;
            end
            REFILL_R: begin
                m.rready = 1'b1;
                if (m.rvalid && m.rlast) state_d = RESP;
            end
            RESP: begin
                if (s.rready) state_d = IDLE;
            end
`ifdef ICACHE_FLUSH_EN
            FLUSH: begin
                if (flush_cnt == IDX_W'(SETS - 1)) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule
